// File: rtl/traffic_phase_ctrl.sv
// Two-direction intersection phase sequencer with internal 1 s prescaler and pedestrian arbitration.
// Optional night flash mode is enabled by defining TRAFFIC_NIGHT_FLASH_EN.
module traffic_phase_ctrl #(
  parameter int CLK_PER_SEC = 50000000,
  parameter int CNT_WIDTH   = 8,
  parameter int T_GREEN     = 25,
  parameter int T_YELLOW    = 3,
  parameter int T_ALLRED    = 1,
  parameter int T_GREEN_MIN = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
`ifdef TRAFFIC_NIGHT_FLASH_EN
  input  logic                 night,
`endif
  input  logic                 ped_req_ns,
  input  logic                 ped_req_ew,
  output logic [2:0]           light_ns,
  output logic [2:0]           light_ew,
  output logic                 walk_ns,
  output logic                 walk_ew,
  output logic [CNT_WIDTH-1:0] remain,
  output logic [2:0]           phase,
  output logic                 sec_tick
);

  localparam int PW = (CLK_PER_SEC > 1) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [CNT_WIDTH-1:0] R_ONE    = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] R_ZERO   = '0;
  localparam logic [CNT_WIDTH-1:0] R_GREEN  = CNT_WIDTH'(T_GREEN);
  localparam logic [CNT_WIDTH-1:0] R_YELLOW = CNT_WIDTH'(T_YELLOW);
  localparam logic [CNT_WIDTH-1:0] R_ALLRED = CNT_WIDTH'(T_ALLRED);
  // remain at or below this value means at least T_GREEN_MIN seconds have elapsed at the tick
  localparam logic [CNT_WIDTH-1:0] R_CUT_AT = CNT_WIDTH'(T_GREEN - T_GREEN_MIN + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_NS_G  = 3'd1,
    S_NS_Y  = 3'd2,
    S_AR_A  = 3'd3,
    S_EW_G  = 3'd4,
    S_EW_Y  = 3'd5,
    S_AR_B  = 3'd6,
    S_FLASH = 3'd7
  } state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic [CNT_WIDTH-1:0] remain_q, remain_d;
  logic                 pend_ns_q, pend_ns_d;
  logic                 pend_ew_q, pend_ew_d;
  logic                 walk_ns_q, walk_ns_d;
  logic                 walk_ew_q, walk_ew_d;
  logic [2:0]           light_ns_q, light_ns_d;
  logic [2:0]           light_ew_q, light_ew_d;
  logic                 sec_tick_q, sec_tick_d;
  logic                 tick, last_sec, green_cut, entry;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic                 flash_q, flash_d;
`endif

  always_comb begin
    tick      = (state_q != S_IDLE) && (presc_q == PRESC_LAST);
    last_sec  = tick && (remain_q == R_ONE);
    green_cut = (remain_q <= R_CUT_AT);

    state_d = state_q;
    case (state_q)
      S_IDLE: if (en) state_d = S_AR_B;
      S_NS_G: if (last_sec || (tick && pend_ew_q && green_cut)) state_d = S_NS_Y;
      S_NS_Y: if (last_sec) state_d = S_AR_A;
      S_AR_A: if (last_sec) state_d = S_EW_G;
      S_EW_G: if (last_sec || (tick && pend_ns_q && green_cut)) state_d = S_EW_Y;
      S_EW_Y: if (last_sec) state_d = S_AR_B;
      S_AR_B: if (last_sec) state_d = S_NS_G;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      S_FLASH: if (tick) state_d = S_AR_B;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef TRAFFIC_NIGHT_FLASH_EN
    if (night && (state_q != S_IDLE)) state_d = S_FLASH;
`endif
    if (!en) state_d = S_IDLE;
    entry = (state_d != state_q);

    if ((state_d == S_IDLE) || entry || tick) presc_d = '0;
    else                                      presc_d = presc_q + PRESC_ONE;

    remain_d = remain_q;
    if (entry) begin
      case (state_d)
        S_NS_G, S_EW_G: remain_d = R_GREEN;
        S_NS_Y, S_EW_Y: remain_d = R_YELLOW;
        S_AR_A, S_AR_B: remain_d = R_ALLRED;
        default:        remain_d = R_ZERO;
      endcase
    end else if (tick && (remain_q != R_ZERO)) begin
      remain_d = remain_q - R_ONE;
    end

    pend_ns_d = pend_ns_q | (ped_req_ns && (state_q != S_IDLE));
    pend_ew_d = pend_ew_q | (ped_req_ew && (state_q != S_IDLE));
    walk_ns_d = walk_ns_q;
    walk_ew_d = walk_ew_q;
    // a request seen in the very cycle the green is entered is granted immediately
    if (entry && (state_d == S_NS_G)) begin
      walk_ns_d = pend_ns_q | ped_req_ns;
      pend_ns_d = 1'b0;
    end else if (state_d != S_NS_G) begin
      walk_ns_d = 1'b0;
    end
    if (entry && (state_d == S_EW_G)) begin
      walk_ew_d = pend_ew_q | ped_req_ew;
      pend_ew_d = 1'b0;
    end else if (state_d != S_EW_G) begin
      walk_ew_d = 1'b0;
    end
    if (state_d == S_IDLE) begin
      pend_ns_d = 1'b0;
      pend_ew_d = 1'b0;
    end

`ifdef TRAFFIC_NIGHT_FLASH_EN
    flash_d = flash_q;
    if (entry && (state_d == S_FLASH))       flash_d = 1'b1;
    else if ((state_q == S_FLASH) && tick)   flash_d = ~flash_q;
    if ((state_q == S_FLASH) || (state_d == S_FLASH)) begin
      pend_ns_d = 1'b0;
      pend_ew_d = 1'b0;
    end
`endif

    sec_tick_d = (state_d != S_IDLE) && (presc_d == PRESC_LAST);

    light_ns_d = 3'b000;
    light_ew_d = 3'b000;
    case (state_d)
      S_NS_G: begin light_ns_d = 3'b001; light_ew_d = 3'b100; end
      S_NS_Y: begin light_ns_d = 3'b010; light_ew_d = 3'b100; end
      S_AR_A, S_AR_B: begin light_ns_d = 3'b100; light_ew_d = 3'b100; end
      S_EW_G: begin light_ns_d = 3'b100; light_ew_d = 3'b001; end
      S_EW_Y: begin light_ns_d = 3'b100; light_ew_d = 3'b010; end
`ifdef TRAFFIC_NIGHT_FLASH_EN
      S_FLASH: begin
        light_ns_d = flash_d ? 3'b010 : 3'b000;
        light_ew_d = flash_d ? 3'b010 : 3'b000;
      end
`endif
      default: begin light_ns_d = 3'b000; light_ew_d = 3'b000; end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      presc_q    <= '0;
      remain_q   <= '0;
      pend_ns_q  <= 1'b0;
      pend_ew_q  <= 1'b0;
      walk_ns_q  <= 1'b0;
      walk_ew_q  <= 1'b0;
      light_ns_q <= 3'b000;
      light_ew_q <= 3'b000;
      sec_tick_q <= 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      remain_q   <= remain_d;
      pend_ns_q  <= pend_ns_d;
      pend_ew_q  <= pend_ew_d;
      walk_ns_q  <= walk_ns_d;
      walk_ew_q  <= walk_ew_d;
      light_ns_q <= light_ns_d;
      light_ew_q <= light_ew_d;
      sec_tick_q <= sec_tick_d;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      flash_q    <= flash_d;
`endif
    end
  end

  assign light_ns = light_ns_q;
  assign light_ew = light_ew_q;
  assign walk_ns  = walk_ns_q;
  assign walk_ew  = walk_ew_q;
  assign remain   = remain_q;
  assign phase    = state_q;
  assign sec_tick = sec_tick_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus random requests/enable drops,
// checked against a phase/elapsed-cycle reference model.
module tb_traffic_phase_ctrl;
  localparam int CPS  = 4;
  localparam int TG   = 6;
  localparam int TY   = 2;
  localparam int TA   = 1;
  localparam int TMIN = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en = 1'b0;
  logic ped_req_ns = 1'b0;
  logic ped_req_ew = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
  logic night = 1'b0;
`endif
  logic [2:0] light_ns, light_ew, phase;
  logic       walk_ns, walk_ew, sec_tick;
  logic [7:0] remain;

  traffic_phase_ctrl #(
    .CLK_PER_SEC(CPS), .CNT_WIDTH(8), .T_GREEN(TG), .T_YELLOW(TY),
    .T_ALLRED(TA), .T_GREEN_MIN(TMIN)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
`ifdef TRAFFIC_NIGHT_FLASH_EN
    .night(night),
`endif
    .ped_req_ns(ped_req_ns), .ped_req_ew(ped_req_ew),
    .light_ns(light_ns), .light_ew(light_ew), .walk_ns(walk_ns), .walk_ew(walk_ew),
    .remain(remain), .phase(phase), .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // reference model: current phase, cycles spent in it, latched requests, granted walks
  int m_ph, m_cyc;
  bit m_pn, m_pe, m_wn, m_we;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dur_of(input int ph);
    case (ph)
      1, 4:    return TG;
      2, 5:    return TY;
      3, 6:    return TA;
      default: return 0;
    endcase
  endfunction

  function automatic logic [5:0] lamps_of(input int ph);
    case (ph)
      1:       return {3'b001, 3'b100};
      2:       return {3'b010, 3'b100};
      3, 6:    return {3'b100, 3'b100};
      4:       return {3'b100, 3'b001};
      5:       return {3'b100, 3'b010};
      default: return 6'b000000;
    endcase
  endfunction

  task automatic model_reset();
    m_ph = 0; m_cyc = 0; m_pn = 0; m_pe = 0; m_wn = 0; m_we = 0;
  endtask

  task automatic model_step();
    int secs, nxt;
    bit leave, opp, green;
    if (!en) begin model_reset(); return; end
    if (m_ph == 0) begin m_ph = 6; m_cyc = 0; return; end
    green = (m_ph == 1) || (m_ph == 4);
    opp   = (m_ph == 1) ? m_pe : (m_ph == 4) ? m_pn : 1'b0;
    secs  = m_cyc / CPS + 1;
    leave = (m_cyc % CPS == CPS - 1) &&
            ((secs == dur_of(m_ph)) || (green && opp && secs >= TMIN));
    m_pn = m_pn | ped_req_ns;
    m_pe = m_pe | ped_req_ew;
    if (leave) begin
      nxt = (m_ph == 6) ? 1 : m_ph + 1;
      m_wn = 0; m_we = 0;
      if (nxt == 1) begin m_wn = m_pn; m_pn = 0; end
      if (nxt == 4) begin m_we = m_pe; m_pe = 0; end
      m_ph = nxt; m_cyc = 0;
    end else begin
      m_cyc++;
    end
  endtask

  task automatic compare_all();
    logic [5:0] lp;
    int rem;
    lp  = lamps_of(m_ph);
    rem = (m_ph == 0) ? 0 : dur_of(m_ph) - m_cyc / CPS;
    check_val("phase", 32'(phase), 32'(m_ph));
    check_val("light_ns", 32'(light_ns), 32'(lp[5:3]));
    check_val("light_ew", 32'(light_ew), 32'(lp[2:0]));
    check_val("walks", 32'({walk_ns, walk_ew}), 32'({m_wn, m_we}));
    check_val("remain", 32'(remain), 32'(rem));
    check_val("sec_tick", 32'(sec_tick), 32'((m_ph != 0) && (m_cyc % CPS == CPS - 1)));
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic run_until(input int ph, input int cyc, input string tag);
    int n = 0;
    while (!(m_ph == ph && m_cyc == cyc) && n < 400) begin
      step_cycle();
      n++;
    end
    check_val(tag, (n < 400) ? 32'(phase) : 32'hFFFF, 32'(ph));
  endtask

  task automatic phase_len(input int ph, input int exp_len, input string tag);
    int n = 1;
    do begin
      step_cycle();
      if (phase == 3'(ph)) n++;
    end while (phase == 3'(ph) && n < 100);
    check_val(tag, 32'(n), 32'(exp_len));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1;
    check_val("rst_phase", 32'(phase), 0);
    check_val("rst_lamps", 32'({light_ns, light_ew}), 0);
    check_val("rst_remain", 32'(remain), 0);
    check_val("rst_misc", 32'({walk_ns, walk_ew, sec_tick}), 0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // free-running cycle, no requests
    step_cycle();
    phase_len(6, 4, "first_ar_b_len");
    phase_len(1, 24, "ns_g_full_len");
    repeat (100) step_cycle();

    // EW request at first NS_G cycle shortens NS_G and grants EW walk
    run_until(1, 0, "reach_ns_g_a");
    ped_req_ew = 1'b1;
    step_cycle();
    ped_req_ew = 1'b0;
    begin
      int n = 2;
      while (phase == 3'd1 && n < 100) begin step_cycle(); if (phase == 3'd1) n++; end
      check_val("ns_g_cut_len", 32'(n), 8);
    end
    run_until(4, 0, "reach_ew_g_a");
    check_val("walk_ew_granted", 32'(walk_ew), 1);
    phase_len(4, 24, "ew_g_walk_len");
    check_val("walk_ew_dropped", 32'(walk_ew), 0);

    // NS request mid NS_G: no walk now, EW_G cut, next NS_G walks
    run_until(1, 3, "reach_ns_g_b");
    ped_req_ns = 1'b1;
    step_cycle();
    ped_req_ns = 1'b0;
    check_val("walk_ns_not_mid", 32'(walk_ns), 0);
    run_until(4, 0, "reach_ew_g_b");
    phase_len(4, 8, "ew_g_cut_len");
    run_until(1, 0, "reach_ns_g_c");
    check_val("walk_ns_granted", 32'(walk_ns), 1);

    // enable dropped mid NS_Y, then restarted
    run_until(2, 3, "reach_ns_y");
    en = 1'b0;
    step_cycle();
    check_val("idle_after_en_drop", 32'({phase, light_ns, light_ew}), 0);
    en = 1'b1;
    step_cycle();
    phase_len(6, 4, "restart_ar_b_len");

    // async reset mid EW_G loses the pending NS request
    run_until(4, 2, "reach_ew_g_c");
    ped_req_ns = 1'b1;
    step_cycle();
    ped_req_ns = 1'b0;
    run_until(4, 5, "reach_ew_g_d");
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_phase", 32'(phase), 0);
    check_val("async_rst_out", 32'({light_ns, light_ew, walk_ns, walk_ew, remain, sec_tick}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    run_until(1, 0, "reach_ns_g_d");
    check_val("walk_ns_lost", 32'(walk_ns), 0);

`ifdef TRAFFIC_NIGHT_FLASH_EN
    run_until(4, 2, "reach_ew_g_night");
    night = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      check_val("flash_phase", 32'(phase), 7);
      check_val("flash_lamps", 32'({light_ns, light_ew}), (i < 4) ? 32'h12 : 32'h0);
      check_val("flash_misc", 32'({walk_ns, walk_ew, remain}), 0);
      @(negedge clk);
    end
    night = 1'b0;
    begin
      int n = 0;
      while (phase != 3'd6 && n < 20) begin
        @(posedge clk);
        #1;
        n++;
        @(negedge clk);
      end
      check_val("flash_exit_len", 32'(n), 5);
    end
    model_reset();
    m_ph = 6;
    phase_len(6, 4, "flash_ar_b_len");
`endif

    // random requests and occasional enable drops
    for (int i = 0; i < 1500; i++) begin
      en         = ($urandom_range(0, 199) != 0);
      ped_req_ns = ($urandom_range(0, 29) == 0);
      ped_req_ew = ($urandom_range(0, 29) == 0);
      step_cycle();
    end
    en = 1'b1;
    ped_req_ns = 1'b0;
    ped_req_ew = 1'b0;
    repeat (20) step_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_phase_ctrl.md
Name: traffic_phase_ctrl

Overview:
- Two-direction intersection sequencer: NS and EW approaches, built on the same one-hot light encoding as the single-approach light FSM (bit0 green, bit1 yellow, bit2 red).
- Generates the 1 s tick internally from a clock prescaler and counts the phase durations down.
- Inserts an all-red clearance between the two directions.
- Arbitrates pedestrian crossing requests. A pending request shortens the opposing green and grants a walk signal.
- Sits between the top-level enable/button inputs and the lamp/countdown display drivers.

Parameters:
- CLK_PER_SEC, 50000000: clk cycles per second tick; must be ≥2.
- CNT_WIDTH, 8: width of the second countdown.
- T_GREEN, 25: green duration in seconds.
- T_YELLOW, 3: yellow duration in seconds.
- T_ALLRED, 1: all-red clearance in seconds.
- T_GREEN_MIN, 5: minimum green before a pedestrian request may cut the green; 1 ≤ T_GREEN_MIN ≤ T_GREEN.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run enable; low forces IDLE synchronously.
- ped_req_ns  in  1  request to walk parallel to NS traffic; level or pulse, sampled every cycle.
- ped_req_ew  in  1  request to walk parallel to EW traffic.
- light_ns  out  3  one-hot NS lamps {red, yellow, green}.
- light_ew  out  3  one-hot EW lamps.
- walk_ns  out  1  NS pedestrian walk.
- walk_ew  out  1  EW pedestrian walk.
- remain  out  CNT_WIDTH  seconds left in the current phase, including the current second.
- phase  out  3  state code.
- sec_tick  out  1  one-cycle pulse at each second boundary.

Behaviour:
- Reset (async, rst=1): all outputs are 0, pend_ns/pend_ew are 0, prescaler is 0, state is IDLE. All outputs are registered.
- Phase codes: IDLE=0, NS_G=1, NS_Y=2, AR_A=3, EW_G=4, EW_Y=5, AR_B=6, FLASH=7 (option only).
- Lamp patterns:
  - IDLE: both lamps 000.
  - NS_G: NS=001, EW=100.
  - NS_Y: NS=010, EW=100.
  - AR_A and AR_B: both 100.
  - EW_G: EW=001, NS=100.
  - EW_Y: EW=010, NS=100.
- Prescaler:
  - Counts 0..CLK_PER_SEC-1 while state ≠ IDLE.
  - sec_tick=1 in the cycle the prescaler holds CLK_PER_SEC-1.
  - Prescaler resets to 0 on every phase entry, so each phase lasts exactly T×CLK_PER_SEC cycles.
- Phase entry: remain is loaded with the phase's T (T_GREEN, T_YELLOW or T_ALLRED). Each sec_tick decrements remain.
- Phase exit: happens on a sec_tick with remain==1. The next state and its lamps are visible one cycle after that tick.
- Sequence: IDLE→AR_B (on the cycle after en is seen high)→NS_G→NS_Y→AR_A→EW_G→EW_Y→AR_B→NS_G, and so on.
- en=0 in any state: next cycle is IDLE, lamps 000, walks 0, pends cleared, remain 0.
- Request latching: pend_x is set by ped_req_x in any non-IDLE state.
- Entry into X_G: walk_x is captured as (pend_x | ped_req_x) in the entry cycle and pend_x is cleared. walk_x holds for the whole X_G and drops on exit.
- A request arriving during X_G stays pending for the next X_G; a walk is never granted mid-phase.
- Shortening: in X_G, with pend_y set (y is the opposing direction), the phase exits at the first sec_tick where elapsed = T_GREEN − remain + 1 ≥ T_GREEN_MIN. Natural expiry still applies.
- Shortening never applies to yellow or all-red phases.
- Simultaneous requests in both directions: both latch, and each is served at its own next green.
- remain is 0 in IDLE.

Optional Feature:
- Macro: TRAFFIC_NIGHT_FLASH_EN.
- Defined:
  - Adds input port `night` (1 bit).
  - night=1 in any non-IDLE state moves to FLASH on the next cycle.
  - In FLASH: both lamps are 010 for one second, then 000 for one second, alternating on sec_tick and starting with on. walks=0, remain=0, pends are cleared and ignored.
  - night=0 in FLASH moves to AR_B at the next sec_tick.
  - en=0 still wins and forces IDLE.
- Undefined: no `night` port, and phase code 7 never occurs.

Test Plan:
- Use CLK_PER_SEC=4, T_GREEN=6, T_YELLOW=2, T_ALLRED=1, T_GREEN_MIN=2 for all scenarios.
- Reset then en=1, no requests:
  - phase goes 6 (4 cycles), 1 (24 cycles), 2 (8), 3 (4), 4 (24), 5 (8), 6 (4), for a 72-cycle period.
  - light_ns=001 in NS_G; remain counts 6,5,4,3,2,1; sec_tick every 4 cycles.
- ped_req_ew pulse in the first cycle of NS_G → NS_G lasts 8 cycles, then NS_Y → AR_A → EW_G with walk_ew=1 for all 24 cycles of EW_G, and walk_ew=0 afterwards.
- ped_req_ns during NS_G → walk_ns stays 0 in this NS_G. EW_G is cut to 8 cycles, and the next NS_G has walk_ns=1.
- en dropped mid-NS_Y → next cycle phase=0, lamps 000, remain=0. Re-raising en restarts at AR_B with a full 4-cycle clearance.
- rst asserted mid-EW_G, asynchronously between clock edges → outputs go to 0 immediately; the pending request is lost after release.
- With TRAFFIC_NIGHT_FLASH_EN, night=1 during EW_G → phase=7, both lamps 010 for 4 cycles and 000 for 4 cycles. night=0 → AR_B at the next tick, then NS_G.
